// File: rtl/regfile_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   function automatic int addr_w(input int nregs);
      return (nregs < 2) ? 1 : $clog2(nregs);
   endfunction

   // Low bit of lane k in a flattened vector of w-bit lanes.
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending long-latency write tracker: busy bits, busy count, mark acceptance, protocol errors.
// mark_ok_o is combinational; busy/count/err update on the clock. Rejected marks must be held by issue.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = addr_w(NREGS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             mark_i,
   input  logic [AW-1:0]    mark_addr_i,
   input  logic             wa_wen_i,
   input  logic [AW-1:0]    wa_addr_i,
   input  logic             wb_wen_i,
   input  logic [AW-1:0]    wb_addr_i,
   output logic [NREGS-1:0] busy_o,
   output logic             mark_ok_o,
   output logic [AW:0]      busy_cnt_o,
   output logic             err_o
);

   logic [NREGS-1:0] busy_q, busy_d;
   logic [AW:0]      busy_cnt_q, busy_cnt_d;
   logic             err_q, err_d;
   logic             clr, set, inc, dec;

   always_comb begin
      clr       = wb_wen_i && (wb_addr_i != '0);
      mark_ok_o = mark_i && ((mark_addr_i == '0) || !busy_q[mark_addr_i] ||
                             (wb_wen_i && (wb_addr_i == mark_addr_i)));
      set       = mark_ok_o && (mark_addr_i != '0);

      busy_d = busy_q;
      if (clr) busy_d[wb_addr_i] = 1'b0;
      if (set) busy_d[mark_addr_i] = 1'b1;
      busy_d[0] = 1'b0;

      // Count real bit transitions so a stray retire of an idle register cannot underflow.
      inc = set && !busy_q[mark_addr_i];
      dec = clr && busy_q[wb_addr_i] && !(set && (mark_addr_i == wb_addr_i));
      busy_cnt_d = busy_cnt_q;
      if (inc && !dec) busy_cnt_d = busy_cnt_q + (AW+1)'(1);
      if (dec && !inc) busy_cnt_d = busy_cnt_q - (AW+1)'(1);

      err_d = (clr && !busy_q[wb_addr_i]) ||
              (wa_wen_i && busy_q[wa_addr_i] && !(clr && (wb_addr_i == wa_addr_i))) ||
              (wa_wen_i && wb_wen_i && (wa_addr_i == wb_addr_i) && (wa_addr_i != '0));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q     <= '0;
         busy_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
         err_q      <= err_d;
      end
   end

   assign busy_o     = busy_q;
   assign busy_cnt_o = busy_cnt_q;
   assign err_o      = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two write ports, optional write-to-read bypass and a long-latency scoreboard.
// Reads are 0-cycle combinational; writes land on the clock; issue stalls by retrying rejected marks.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int NRD    = 2,
   parameter int FWD_EN = 1,
   localparam int AW    = addr_w(NREGS)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [NRD*AW-1:0]   rs_addr_i,
   output logic [NRD*XLEN-1:0] rs_data_o,
   output logic [NRD-1:0]      rs_busy_o,
   input  logic                wa_wen_i,
   input  logic [AW-1:0]       wa_addr_i,
   input  logic [XLEN-1:0]     wa_data_i,
   input  logic                wb_wen_i,
   input  logic [AW-1:0]       wb_addr_i,
   input  logic [XLEN-1:0]     wb_data_i,
   input  logic                mark_i,
   input  logic [AW-1:0]       mark_addr_i,
   output logic                mark_ok_o,
   output logic [AW:0]         busy_cnt_o,
   output logic                err_o
);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy;

   rf_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .mark_i      (mark_i),
      .mark_addr_i (mark_addr_i),
      .wa_wen_i    (wa_wen_i),
      .wa_addr_i   (wa_addr_i),
      .wb_wen_i    (wb_wen_i),
      .wb_addr_i   (wb_addr_i),
      .busy_o      (busy),
      .mark_ok_o   (mark_ok_o),
      .busy_cnt_o  (busy_cnt_o),
      .err_o       (err_o)
   );

   // Port A is applied last so it wins a same-address collision.
   always_comb begin
      regs_d = regs_q;
      if (wb_wen_i && (wb_addr_i != '0)) regs_d[wb_addr_i] = wb_data_i;
      if (wa_wen_i && (wa_addr_i != '0)) regs_d[wa_addr_i] = wa_data_i;
      regs_d[0] = '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) regs_q <= '{default: '0};
      else       regs_q <= regs_d;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;

      assign addr = rs_addr_i[slice_lo(k, AW) +: AW];

      always_comb begin
         data = regs_q[addr];
         if (FWD_EN != 0) begin
            if (wa_wen_i && (wa_addr_i == addr))      data = wa_data_i;
            else if (wb_wen_i && (wb_addr_i == addr)) data = wb_data_i;
         end
         if (addr == '0) data = '0;
      end

      assign rs_data_o[slice_lo(k, XLEN) +: XLEN] = data;
      assign rs_busy_o[k] = busy[addr] &&
                            !((FWD_EN != 0) && wb_wen_i && (wb_addr_i == addr));
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: two instances (bypass on / bypass off) share stimulus; vector table plus corner sequences.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rs_addr;
   logic        wa_wen, wb_wen, mark;
   logic [4:0]  wa_addr, wb_addr, mark_addr;
   logic [31:0] wa_data, wb_data;

   logic [63:0] d_f, d_n;
   logic [1:0]  b_f, b_n;
   logic        ok_f, ok_n, err_f, err_n;
   logic [5:0]  cnt_f, cnt_n;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   regfile_sb #(.FWD_EN(1)) u_fwd (
      .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(d_f), .rs_busy_o(b_f),
      .wa_wen_i(wa_wen), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
      .wb_wen_i(wb_wen), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .mark_i(mark), .mark_addr_i(mark_addr), .mark_ok_o(ok_f),
      .busy_cnt_o(cnt_f), .err_o(err_f)
   );

   regfile_sb #(.FWD_EN(0)) u_nofwd (
      .clk_i(clk), .rst_i(rst), .rs_addr_i(rs_addr), .rs_data_o(d_n), .rs_busy_o(b_n),
      .wa_wen_i(wa_wen), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
      .wb_wen_i(wb_wen), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
      .mark_i(mark), .mark_addr_i(mark_addr), .mark_ok_o(ok_n),
      .busy_cnt_o(cnt_n), .err_o(err_n)
   );

   typedef struct {
      logic        wa_wen; logic [4:0] wa_addr; logic [31:0] wa_data;
      logic        wb_wen; logic [4:0] wb_addr; logic [31:0] wb_data;
      logic        mark;   logic [4:0] mark_addr;
      logic [4:0]  rs0;    logic [4:0] rs1;
      logic [31:0] e_d0;   logic [31:0] e_d1; logic [31:0] e_n0;
      logic        e_b0;   logic e_b1; logic e_ok;
      logic [5:0]  e_cnt;  logic e_err;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle();
      wa_wen = 0; wa_addr = 0; wa_data = 0;
      wb_wen = 0; wb_addr = 0; wb_data = 0;
      mark = 0; mark_addr = 0;
   endtask

   initial begin
      // wa(en,a,d) wb(en,a,d) mark(en,a) rs0 rs1 | d0 d1 nofwd_d0 b0 b1 ok | cnt err after edge
      vecs[0]  = '{0,0,0,           0,0,0,           0,0, 0,5, 0,0,0,                   0,0,0, 0,0};
      vecs[1]  = '{1,5,32'hDEADBEEF,0,0,0,           0,0, 5,0, 32'hDEADBEEF,0,0,        0,0,0, 0,0};
      vecs[2]  = '{0,0,0,           0,0,0,           0,0, 5,5, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF, 0,0,0, 0,0};
      vecs[3]  = '{1,0,32'h1234,    1,0,32'h1234,    0,0, 0,0, 0,0,0,                   0,0,0, 0,0};
      vecs[4]  = '{0,0,0,           0,0,0,           1,7, 7,5, 0,32'hDEADBEEF,0,        0,0,1, 1,0};
      vecs[5]  = '{0,0,0,           0,0,0,           1,7, 7,5, 0,32'hDEADBEEF,0,        1,0,0, 1,0};
      vecs[6]  = '{0,0,0,           1,7,32'h55,      1,7, 7,7, 32'h55,32'h55,0,         0,0,1, 1,0};
      vecs[7]  = '{0,0,0,           0,0,0,           0,0, 7,0, 32'h55,0,32'h55,         1,0,0, 1,0};
      vecs[8]  = '{0,0,0,           1,7,32'h77,      0,0, 7,3, 32'h77,0,32'h55,         0,0,0, 0,0};
      vecs[9]  = '{0,0,0,           1,9,32'h9,       0,0, 9,0, 32'h9,0,0,               0,0,0, 0,1};
      vecs[10] = '{0,0,0,           0,0,0,           0,0, 9,7, 32'h9,32'h77,32'h9,      0,0,0, 0,0};
      vecs[11] = '{1,3,32'hAAAA,    1,3,32'hBBBB,    0,0, 3,0, 32'hAAAA,0,0,            0,0,0, 0,1};
      vecs[12] = '{0,0,0,           0,0,0,           0,0, 3,0, 32'hAAAA,0,32'hAAAA,     0,0,0, 0,0};
      vecs[13] = '{0,0,0,           0,0,0,           1,4, 4,0, 0,0,0,                   0,0,1, 1,0};
      vecs[14] = '{1,4,32'h44,      0,0,0,           0,0, 4,0, 32'h44,0,0,              1,0,0, 1,1};
      vecs[15] = '{0,0,0,           1,4,32'h4B,      0,0, 4,0, 32'h4B,0,32'h44,         0,0,0, 0,0};
      vecs[16] = '{0,0,0,           0,0,0,           1,0, 0,4, 0,32'h4B,0,              0,0,1, 0,0};

      idle(); rs_addr = '0; rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 0;
      #1;
      chk("rst_cnt", 32'(cnt_f), 0);
      chk("rst_err", 32'(err_f), 0);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         wa_wen = vecs[i].wa_wen; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
         wb_wen = vecs[i].wb_wen; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
         mark = vecs[i].mark; mark_addr = vecs[i].mark_addr;
         rs_addr = {vecs[i].rs1, vecs[i].rs0};
         #1;
         chk($sformatf("v%0d_d0", i), d_f[31:0], vecs[i].e_d0);
         chk($sformatf("v%0d_d1", i), d_f[63:32], vecs[i].e_d1);
         chk($sformatf("v%0d_nofwd_d0", i), d_n[31:0], vecs[i].e_n0);
         chk($sformatf("v%0d_b0", i), 32'(b_f[0]), 32'(vecs[i].e_b0));
         chk($sformatf("v%0d_b1", i), 32'(b_f[1]), 32'(vecs[i].e_b1));
         chk($sformatf("v%0d_ok", i), 32'(ok_f), 32'(vecs[i].e_ok));
         @(posedge clk); #1;
         chk($sformatf("v%0d_cnt", i), 32'(cnt_f), 32'(vecs[i].e_cnt));
         chk($sformatf("v%0d_err", i), 32'(err_f), 32'(vecs[i].e_err));
      end

      // Fill the scoreboard, then drain it with forwarded retires.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk); idle(); mark = 1; mark_addr = 5'(i);
         #1 chk($sformatf("fill%0d_ok", i), 32'(ok_f), 1);
         @(posedge clk); #1;
         chk($sformatf("fill%0d_cnt", i), 32'(cnt_f), 32'(i));
      end
      for (int i = 1; i < 32; i++) begin
         @(negedge clk); idle();
         wb_wen = 1; wb_addr = 5'(i); wb_data = 32'(i) + 32'h100;
         rs_addr = {5'(i), 5'(i)};
         #1;
         chk($sformatf("drain%0d_d", i), d_f[31:0], 32'(i) + 32'h100);
         chk($sformatf("drain%0d_b", i), 32'(b_f[0]), 0);
         chk($sformatf("drain%0d_nofwd_b", i), 32'(b_n[0]), 1);
         @(posedge clk); #1;
         chk($sformatf("drain%0d_cnt", i), 32'(cnt_f), 32'(31 - i));
         chk($sformatf("drain%0d_err", i), 32'(err_f), 0);
      end

      // Reset mid-sequence, with a write and a mark in the reset cycle.
      for (int i = 1; i < 6; i++) begin
         @(negedge clk); idle(); mark = 1; mark_addr = 5'(i);
      end
      @(posedge clk); #1;
      chk("mid_cnt_pre", 32'(cnt_f), 5);
      @(negedge clk);
      rst = 1; idle(); mark = 1; mark_addr = 6; wa_wen = 1; wa_addr = 6; wa_data = 32'h66;
      @(posedge clk); #1;
      chk("mid_rst_cnt", 32'(cnt_f), 0);
      @(negedge clk); rst = 0; idle();
      for (int i = 0; i < 32; i++) begin
         rs_addr = {5'(31 - i), 5'(i)};
         #1;
         chk($sformatf("clr%0d_d0", i), d_f[31:0], 0);
         chk($sformatf("clr%0d_d1", i), d_f[63:32], 0);
         chk($sformatf("clr%0d_b", i), 32'(b_f), 0);
      end
      chk("clr_err", 32'(err_f), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle integer register file, built for the pipelined core.
- Provides NRD asynchronous read ports and two write ports:
  - port A: single-cycle ALU results.
  - port B: long-latency load/mul/div results.
- Adds write-to-read bypass and a per-register scoreboard that tracks pending long-latency writes, so the issue stage can stall on RAW/WAW hazards.
- x0 stays hardwired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2 and at least 2.
- NRD, 2, number of read ports.
- FWD_EN, 1, 1 = same-cycle write data bypassed to read ports; 0 = reads return stored value only.
- AW, $clog2(NREGS), register address width (localparam, derived).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rs_addr_i  in  NRD*AW  read addresses; port k at [k*AW +: AW].
- rs_data_o  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN].
- rs_busy_o  out  NRD  source register k has a pending long-latency write.
- wa_wen_i  in  1  port A write enable.
- wa_addr_i  in  AW  port A destination.
- wa_data_i  in  XLEN  port A data.
- wb_wen_i  in  1  port B write enable; also retires the scoreboard entry.
- wb_addr_i  in  AW  port B destination.
- wb_data_i  in  XLEN  port B data.
- mark_i  in  1  issue of a long-latency op; request to set busy[mark_addr_i].
- mark_addr_i  in  AW  destination register of that op.
- mark_ok_o  out  1  combinational; mark accepted this cycle.
- busy_cnt_o  out  AW+1  registered count of busy registers.
- err_o  out  1  registered one-cycle protocol-violation pulse.

Behaviour:
- Reset (rst_i=1 at posedge):
  - All registers cleared to 0 and all busy bits cleared.
  - busy_cnt_o=0, err_o=0.
  - Reset has priority over every write and mark in the same cycle.
- Reads are combinational.
  - Address 0 always returns 0 and busy 0.
  - With FWD_EN=1, read priority is:
    1. wa data if wa_wen_i and the address matches.
    2. wb data if wb_wen_i and the address matches.
    3. Stored value.
- rs_busy_o[k] = busy[addr_k] AND NOT (FWD_EN AND wb_wen_i AND wb_addr_i==addr_k). Data being retired this cycle is forwarded, so it is not busy.
- Writes land on the posedge; writes to x0 are discarded.
  - Same address on both ports in one cycle: port A value is stored, and err_o pulses the next cycle (WAW violation).
- Scoreboard, updated at posedge:
  - wb_wen_i with wb_addr_i≠0 clears busy[wb_addr_i].
  - An accepted mark sets busy[mark_addr_i].
  - Set beats clear on the same address in the same cycle; net busy stays 1.
- mark_ok_o = mark_i AND (mark_addr_i==0 OR NOT busy[mark_addr_i] OR (wb_wen_i AND wb_addr_i==mark_addr_i)).
  - Mark to x0 is accepted and has no effect.
  - A rejected mark changes nothing; the issue stage must hold and retry.
- busy_cnt_o tracks the number of set busy bits: +1 on set-only, −1 on clear-only, unchanged on set+clear or no-op. Range is 0..NREGS-1 and never wraps.
- err_o pulses (next cycle) on any of:
  - wb_wen_i to a non-busy, nonzero register.
  - wa_wen_i to a busy register that is not also being cleared by wb this cycle.
  - Same-cycle wa/wb address collision (nonzero).
- Storage and scoreboard state update normally despite err_o.
- Read latency is 0 cycles; write-to-read visibility is the same cycle with FWD_EN=1, otherwise the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - XLEN and NREGS defaults.
  - The AW derivation.
  - Helper functions to slice flattened address/data vectors.
- Sub-module rf_scoreboard holds the busy vector, busy_cnt, mark_ok logic and err_o generation.
- regfile_sb instantiates rf_scoreboard and keeps the storage array, bypass muxes and NRD read ports (generate loop).

Test Plan:
- Reset after arbitrary writes, then read all addresses on 2 ports → every rs_data_o=0, rs_busy_o=0, busy_cnt_o=0.
- wa write x5=0xDEADBEEF while rs0=x5 in the same cycle:
  - FWD_EN=1 → rs_data_o[0]=0xDEADBEEF that cycle.
  - FWD_EN=0 → rs_data_o[0]=0 that cycle, 0xDEADBEEF the next cycle.
- Write x0=0x1234 on both ports → reads of x0 return 0; err_o=1 only if the collision rule applies (it does not for x0, so err_o=0).
- mark x7, then mark x7 again → first mark_ok_o=1, busy_cnt_o=1; second mark_ok_o=0.
  - Then wb x7=0x55 plus mark x7 in the same cycle → mark_ok_o=1, busy stays 1, busy_cnt_o=1, rs_busy_o for x7=0 with data 0x55 during that cycle.
- wb write to non-busy x9 → value 0x9 stored, err_o=1 for exactly one cycle.
  - Also wa and wb both to x3 in the same cycle → x3=wa data, err_o pulse.
- mark x1..x31 on consecutive cycles, then retire all → busy_cnt_o climbs to 31 with no overflow, returns to 0.
  - Asserting rst_i mid-sequence → busy_cnt_o=0 the next cycle.
